// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide controller for the mips16_sc datapath. A MULT or
// DIVU request from the control unit starts a radix-2 shift-add multiply or
// a restoring divide that runs for WIDTH cycles. The fetch stage is held via
// stall while the unit is busy. HI/LO are committed in a single DONE cycle.
//
// Configuration:
//   MULDIV_SIGNED_EN  when defined, op widens to 2 bits
//                     (00 MULTU, 01 DIVU, 10 MULT, 11 DIV). Signed operations
//                     run the unsigned core on operand magnitudes and fix up
//                     the signs when the result is committed.
//
// Parameters:
//   WIDTH        operand width; HI and LO are each WIDTH bits
//   CNT_W        iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   op           operation select (bit 0: 0 = multiply, 1 = divide)
//   operand_a    multiplicand / dividend (rs)
//   operand_b    multiplier / divisor (rt)
//   hi_lo_sl     read-back select: 1 = HI, 0 = LO
//   stall        instruction stall to PC/fetch
//   ready        one-cycle completion pulse
//   div_by_zero  sticky flag for the last divide, cleared on the next start
//   hi, lo       HI / LO registers
//   result       hi_lo_sl ? hi : lo, combinational
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
`ifdef MULDIV_SIGNED_EN
  input  logic [1:0]       op,
`else
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_lo_sl,
  output logic             stall,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  // Iteration datapath registers. For a multiply, acc_hi:acc_lo is the
  // product accumulator with the multiplier shifting out of acc_lo; for a
  // divide, acc_hi is the partial remainder and acc_lo the dividend/quotient.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] addend;     // multiplicand or divisor
  logic [CNT_W-1:0] count;
  logic             op_div_q;

  // ------------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------------
  logic             is_div_in;
  logic             dbz_in;
  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef MULDIV_SIGNED_EN
  logic signed_in;
  logic neg_q;        // product / quotient must be negated at commit
  logic rem_neg_q;    // remainder must be negated at commit

  assign is_div_in = op[0];
  assign signed_in = op[1];
  assign mag_a     = (signed_in && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign mag_b     = (signed_in && operand_b[WIDTH-1]) ? -operand_b : operand_b;
`else
  assign is_div_in = op;
  assign mag_a     = operand_a;
  assign mag_b     = operand_b;
`endif

  assign dbz_in = is_div_in && (operand_b == '0);
  assign accept = (state == IDLE) && start;

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all
      // flops sample the pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    stall     = 1'b0;
    ready     = 1'b0;
    unique case (state)
      IDLE: begin
        // Hold the issuing instruction in the very cycle it asks.
        stall = start;
        if (start) begin
          state_nxt = dbz_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == LAST_ITER) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // One iteration of the shared multiply / divide core
  // ------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_hi_iter;
  logic [WIDTH-1:0] acc_lo_iter;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, keeping the carry as bit WIDTH.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);

  // Divide: the remainder is always below the divisor, so after the left
  // shift it needs one extra bit. Bit WIDTH of the difference is the borrow.
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, addend};

  always_comb begin
    acc_hi_iter = acc_hi;
    acc_lo_iter = acc_lo;
    if (op_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_hi_iter = div_diff[WIDTH-1:0];
        acc_lo_iter = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_iter = rem_sh[WIDTH-1:0];
        acc_lo_iter = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift {carry, upper, multiplier} right by one.
      acc_hi_iter = mul_sum[WIDTH:1];
      acc_lo_iter = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // ------------------------------------------------------------------------
  // Values committed to HI/LO in DONE
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] hi_fin;
  logic [WIDTH-1:0] lo_fin;

`ifdef MULDIV_SIGNED_EN
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q     ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = neg_q     ? -acc_lo           : acc_lo;
  assign rem_fix  = rem_neg_q ? -acc_hi           : acc_hi;
`endif

  always_comb begin
    hi_fin = acc_hi;
    lo_fin = acc_lo;
    if (div_by_zero) begin
      // acc_hi was loaded with the raw operand_a when the request arrived.
      hi_fin = acc_hi;
      lo_fin = '1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (op_div_q) begin
        hi_fin = rem_fix;
        lo_fin = quot_fix;
      end else begin
        {hi_fin, lo_fin} = prod_fix;
      end
`else
      hi_fin = acc_hi;
      lo_fin = acc_lo;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all datapath state is reset, not just the FSM, so a reset in
      // the middle of an operation leaves HI/LO and the accumulators at 0.
      acc_hi      <= '0;
      acc_lo      <= '0;
      addend      <= '0;
      count       <= '0;
      op_div_q    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count       <= '0;
        op_div_q    <= is_div_in;
        div_by_zero <= dbz_in;
        if (dbz_in) begin
          // No iterations run; park the unmodified dividend for HI.
          acc_hi <= operand_a;
          acc_lo <= '0;
          addend <= '0;
        end else if (is_div_in) begin
          acc_hi <= '0;
          acc_lo <= mag_a;
          addend <= mag_b;
        end else begin
          acc_hi <= '0;
          acc_lo <= mag_b;
          addend <= mag_a;
        end
`ifdef MULDIV_SIGNED_EN
        neg_q     <= signed_in && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        rem_neg_q <= signed_in && is_div_in && operand_a[WIDTH-1];
`endif
      end else if (state == BUSY) begin
        acc_hi <= acc_hi_iter;
        acc_lo <= acc_lo_iter;
        count  <= count + CNT_W'(1);
      end else if (state == DONE) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end
    end
  end

  assign result = hi_lo_sl ? hi : lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer in its default (unsigned) build.
// Expected HI/LO come from plain arithmetic (*, /, %), expected timing from
// the documented latency (ready 17 cycles after start, 1 for divide by zero).
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam int LAT_NORMAL = W + 1;
  localparam int LAT_DBZ    = 1;
  localparam int BUDGET     = 40;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         hi_lo_sl;
  logic         stall;
  logic         ready;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_lo_sl    (hi_lo_sl),
    .stall       (stall),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .result      (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: returns {HI, LO} for an unsigned MULT (o = 0) or DIVU.
  function automatic logic [2*W-1:0] model(input logic o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    if (!o)          return wa * wb;
    else if (b == 0) return {a, {W{1'b1}}};
    else             return {a % b, a / b};
  endfunction

  // Issues one request and watches it for up to BUDGET cycles. Cycle 0 is
  // the cycle start is high. Records the stall level per cycle and the first
  // cycle ready is seen (-1 if never), then steps one more cycle so the
  // committed HI/LO are visible on return.
  task automatic run_op(input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int rdy_cyc, output logic [BUDGET-1:0] trace);
    rdy_cyc = -1;
    trace   = '0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock);
      if (c == 0) begin
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
      end else begin
        start = 1'b0;
      end
      #1;
      trace[c] = stall;
      if (ready) begin
        rdy_cyc = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({stall, ready, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got stall/ready/dbz=%b expected 000",
               {stall, ready, div_by_zero});
    end
    checks++;
    if ({hi, lo, result} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got hi=%h lo=%h result=%h expected 0", hi, lo, result);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({stall, ready, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_release: got stall=%b ready=%b hi=%h lo=%h expected idle zeros",
               stall, ready, hi, lo);
    end
  endtask

  task automatic test_mult_basic();
    int rc;
    logic [BUDGET-1:0] tr;
    run_op(1'b0, 16'h0003, 16'h0005, rc, tr);
    checks++;
    if (rc !== LAT_NORMAL) begin
      errors++;
      $display("FAIL mult_latency: got ready cycle %0d expected %0d", rc, LAT_NORMAL);
    end
    checks++;
    if (tr[17:0] !== 18'h1FFFF) begin
      errors++;
      $display("FAIL mult_stall: got stall trace %b expected %b", tr[17:0], 18'h1FFFF);
    end
    checks++;
    if ({hi, lo} !== 32'h0000_000F) begin
      errors++;
      $display("FAIL mult_3x5: got hi=%h lo=%h expected 0000 000f", hi, lo);
    end
  endtask

  task automatic test_mult_max();
    int rc;
    logic [BUDGET-1:0] tr;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, rc, tr);
    checks++;
    if ({hi, lo} !== 32'hFFFE_0001) begin
      errors++;
      $display("FAIL mult_max: got hi=%h lo=%h expected fffe 0001", hi, lo);
    end
    hi_lo_sl = 1'b1;
    #1;
    checks++;
    if (result !== 16'hFFFE) begin
      errors++;
      $display("FAIL result_hi: got %h expected fffe", result);
    end
    hi_lo_sl = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0001) begin
      errors++;
      $display("FAIL result_lo: got %h expected 0001", result);
    end
    // HI/LO must hold while the unit sits idle.
    repeat (5) @(negedge clock);
    #1;
    checks++;
    if ({hi, lo} !== 32'hFFFE_0001) begin
      errors++;
      $display("FAIL hold_idle: got hi=%h lo=%h expected fffe 0001", hi, lo);
    end
  endtask

  task automatic test_divu();
    int rc;
    logic [BUDGET-1:0] tr;
    run_op(1'b1, 16'd100, 16'd7, rc, tr);
    checks++;
    if (rc !== LAT_NORMAL) begin
      errors++;
      $display("FAIL divu_latency: got ready cycle %0d expected %0d", rc, LAT_NORMAL);
    end
    checks++;
    if ({hi, lo, div_by_zero} !== {16'h0002, 16'h000E, 1'b0}) begin
      errors++;
      $display("FAIL divu_100_7: got hi=%h lo=%h dbz=%b expected 0002 000e 0",
               hi, lo, div_by_zero);
    end
  endtask

  task automatic test_div_by_zero();
    int rc;
    logic [BUDGET-1:0] tr;
    run_op(1'b1, 16'h1234, 16'h0000, rc, tr);
    checks++;
    if (rc !== LAT_DBZ) begin
      errors++;
      $display("FAIL dbz_latency: got ready cycle %0d expected %0d", rc, LAT_DBZ);
    end
    checks++;
    if (tr[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL dbz_stall: got stall trace %b expected 01", tr[1:0]);
    end
    checks++;
    if ({hi, lo, div_by_zero} !== {16'h1234, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b expected 1234 ffff 1",
               hi, lo, div_by_zero);
    end
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_sticky: got %b expected 1", div_by_zero);
    end
    run_op(1'b1, 16'd9, 16'd3, rc, tr);
    checks++;
    if ({hi, lo, div_by_zero} !== {16'h0000, 16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL dbz_clear: got hi=%h lo=%h dbz=%b expected 0000 0003 0",
               hi, lo, div_by_zero);
    end
  endtask

  task automatic test_reset_mid_op();
    int rc;
    bit saw_ready;
    logic [BUDGET-1:0] tr;
    // Leave non-zero HI/LO behind so the clear is observable.
    run_op(1'b0, 16'h1234, 16'h0010, rc, tr);
    saw_ready = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      start     = (c == 0);
      op        = 1'b0;
      operand_a = 16'h00FF;
      operand_b = 16'h0101;
      if (c == 8) reset_n = 1'b0;
      #1;
      if (ready) saw_ready = 1'b1;
    end
    checks++;
    if ({hi, lo, stall, ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got hi=%h lo=%h stall=%b ready=%b expected all 0",
               hi, lo, stall, ready);
    end
    repeat (2) begin
      @(negedge clock);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clock);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ready: got ready pulse %b expected none", saw_ready);
    end
    run_op(1'b0, 16'h00FF, 16'h0101, rc, tr);
    checks++;
    if (rc !== LAT_NORMAL || {hi, lo} !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL reset_rerun: got ready cycle %0d hi=%h lo=%h expected %0d 0000 ffff",
               rc, hi, lo, LAT_NORMAL);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp1, exp2;
    int r1, r2, nready;
    exp1   = model(1'b0, 16'h1234, 16'h0010);
    exp2   = model(1'b0, 16'hABCD, 16'h0002);
    r1     = -1;
    r2     = -1;
    nready = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock);
      if (c == 0) begin
        start     = 1'b1;
        op        = 1'b0;
        operand_a = 16'h1234;
        operand_b = 16'h0010;
      end
      if (c == 1) begin
        operand_a = 16'hABCD;
        operand_b = 16'h0002;
      end
      if (c == 19) start = 1'b0;
      #1;
      if (ready) begin
        nready++;
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      if (c == 17) begin
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_stall: got %b expected 0", stall);
        end
      end
      if (c == 18) begin
        checks++;
        if (stall !== 1'b1 || {hi, lo} !== exp1) begin
          errors++;
          $display("FAIL b2b_first: got stall=%b hi=%h lo=%h expected 1 %h %h",
                   stall, hi, lo, exp1[2*W-1:W], exp1[W-1:0]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (r1 !== LAT_NORMAL || r2 !== LAT_NORMAL + 18 || nready !== 2) begin
      errors++;
      $display("FAIL b2b_timing: got ready at %0d and %0d (%0d pulses) expected %0d and %0d (2)",
               r1, r2, nready, LAT_NORMAL, LAT_NORMAL + 18);
    end
    checks++;
    if ({hi, lo} !== exp2) begin
      errors++;
      $display("FAIL b2b_second: got hi=%h lo=%h expected %h %h",
               hi, lo, exp2[2*W-1:W], exp2[W-1:0]);
    end
  endtask

  task automatic test_random();
    int rc, exp_rc;
    logic o, sel;
    logic [W-1:0] a, b, exp_res;
    logic [2*W-1:0] exp;
    logic [BUDGET-1:0] tr;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      exp    = model(o, a, b);
      exp_rc = (o && b == 0) ? LAT_DBZ : LAT_NORMAL;
      run_op(o, a, b, rc, tr);
      checks++;
      if (rc !== exp_rc || {hi, lo} !== exp || div_by_zero !== (o && b == 0)) begin
        errors++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: got cyc=%0d hi=%h lo=%h dbz=%b expected cyc=%0d hi=%h lo=%h dbz=%b",
                 i, o, a, b, rc, hi, lo, div_by_zero, exp_rc,
                 exp[2*W-1:W], exp[W-1:0], (o && b == 0));
      end
      sel      = 1'($urandom_range(0, 1));
      hi_lo_sl = sel;
      exp_res  = sel ? exp[2*W-1:W] : exp[W-1:0];
      #1;
      checks++;
      if (result !== exp_res) begin
        errors++;
        $display("FAIL rand_result_%0d sel=%b: got %h expected %h", i, sel, result, exp_res);
      end
    end
    hi_lo_sl = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    hi_lo_sl  = 1'b0;
    test_reset();
    test_mult_basic();
    test_mult_max();
    test_divu();
    test_div_by_zero();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the mips16_sc datapath.
- Accepts a MULT or DIVU request from the control unit and runs a radix-2 shift-add / restoring-divide datapath for WIDTH cycles.
- Holds the fetch stage via stall while busy, then commits HI/LO.
- The existing hi_lo_sl control selects which register is read back onto the register-file write path.

Parameters:
WIDTH, 16, operand width; HI and LO are each WIDTH bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request pulse from control unit; sampled only in IDLE
op  input  1  0 = MULT (unsigned), 1 = DIVU
operand_a  input  WIDTH  multiplicand / dividend (rs)
operand_b  input  WIDTH  multiplier / divisor (rt)
hi_lo_sl  input  1  read select: 1 = HI, 0 = LO
stall  output  1  instruction stall to PC/fetch (instr_stall_sl)
ready  output  1  one-cycle completion pulse (ready)
div_by_zero  output  1  sticky flag for the last DIVU, cleared on next start
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
result  output  WIDTH  hi_lo_sl ? hi : lo, combinational

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - State goes to IDLE.
  - hi, lo, counter and internal accumulators are cleared to 0.
  - stall = 0, ready = 0, div_by_zero = 0.
  - Applies at any time, including mid-operation. The partial result is discarded and HI/LO read 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = start (combinational), so the issuing instruction is held in the same cycle.
  - On start = 1, latch op, operand_a and operand_b; counter = 0; clear div_by_zero.
  - If op = DIVU and operand_b = 0: set div_by_zero, go to DONE.
  - Otherwise go to BUSY.
- BUSY:
  - stall = 1.
  - One iteration per cycle; counter increments.
  - After iteration WIDTH-1 (counter = WIDTH-1), go to DONE.
  - start is ignored.
- MULT iteration:
  - 2*WIDTH accumulator, multiplier shifted right.
  - If the multiplier LSB = 1, add the multiplicand into the upper half with carry-out.
  - Then shift the {carry, acc} pair right by 1.
  - Final product is {HI, LO}, unsigned, no overflow possible.
- DIVU iteration:
  - Restoring division.
  - Shift {rem, quot} left by 1, then trial subtract the divisor from rem.
  - If no borrow, keep the difference and set the quotient LSB; otherwise restore.
  - Final: LO = quotient, HI = remainder.
- DONE (exactly 1 cycle):
  - Write hi/lo; ready = 1; stall = 0, so the PC advances on this edge. Next state is IDLE.
  - DIVU by zero writes LO = all ones and HI = operand_a.
  - start in DONE is ignored; the controller re-accepts on the following cycle.
- Latency:
  - Normal op: start in cycle 0, ready in cycle WIDTH+1 (17 cycles for WIDTH = 16). hi/lo are valid from the edge ending the DONE cycle.
  - Divide-by-zero: ready in cycle 1.
- hi/lo hold their values between operations. result reflects hi_lo_sl immediately.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- When defined:
  - op widens to 2 bits: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
  - Signed ops take operand magnitudes in the IDLE->BUSY transition and run the unsigned core.
  - In DONE, the product is negated if the operand signs differ.
  - Quotient sign = sign_a XOR sign_b; remainder takes the sign of the dividend.
  - Latency is unchanged. DIV by zero: LO = all ones, HI = operand_a (unmodified).
  - Special case: DIV of 0x8000 by 0xFFFF gives LO = 0x8000, HI = 0.
- When not defined: op is 1 bit, unsigned only, and no sign logic is synthesised.

Test Plan:
- MULT 0x0003 * 0x0005 -> stall high in cycles 0-16, ready pulse in cycle 17; hi = 0x0000, lo = 0x000F.
- MULT 0xFFFF * 0xFFFF -> hi = 0xFFFE, lo = 0x0001; result = 0xFFFE with hi_lo_sl = 1 and 0x0001 with hi_lo_sl = 0.
- DIVU 100 / 7 -> lo = 0x000E, hi = 0x0002, div_by_zero = 0, ready in cycle 17.
- DIVU 0x1234 / 0 -> ready in cycle 1; lo = 0xFFFF, hi = 0x1234, div_by_zero = 1; next DIVU 9/3 clears the flag and gives lo = 3, hi = 0.
- Assert reset_n low in cycle 8 of MULT 0x00FF * 0x0101 -> hi = lo = 0 and state IDLE immediately, no ready pulse; a subsequent start runs normally (product 0xFFFF).
- start held high continuously for two back-to-back MULTs -> second op is accepted only on the cycle after DONE; two ready pulses 18 cycles apart; the start pulse during BUSY does not disturb the first result.
